mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage controller between the EX/MEM pipeline register and the register-file write-back.
- Consumes EX/MEM outputs and runs a request/acknowledge transaction to variable-latency data memory for loads and stores.
- Stalls upstream while a transaction is in flight, aligns and sign-extends load data, selects write-back data, and registers the MEM/WB outputs.

Parameters:
- TIMEOUT_CYC, 255: max cycles in BUSY before abort (only with MEM_TIMEOUT_EN).
- CNT_W, 8: timeout counter width; must hold TIMEOUT_CYC.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  reset; synchronous, active-low.
- D_MemRead  in  1  load in EX/MEM.
- D_MEM_WEN  in  1  store in EX/MEM; active-low (0 = write).
- D_MEM_BE  in  4  byte enables for store.
- LD_TYPE  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ALUOUT_EXMEM  in  32  memory address / ALU result.
- ST_DATA_EXMEM  in  32  unshifted store data.
- ADD_PC_EXMEM  in  32  PC+4.
- RWSrc_EXMEM  in  2  write-back select: 0 ALU, 1 load, 2 PC+4.
- RF_WE_EXMEM  in  1  register write enable.
- WA_EXMEM  in  5  destination register.
- HALT_EXMEM  in  1  halt marker.
- MEM_REQ  out  1  memory request, registered.
- MEM_ADDR  out  32  word address {ALUOUT[31:2],2'b00}.
- MEM_WEN  out  1  active-low write.
- MEM_BE  out  4  byte enables.
- MEM_WDATA  out  32  store data shifted left by 8*ALUOUT[1:0].
- MEM_RDATA  in  32  word read data, valid with MEM_ACK.
- MEM_ACK  in  1  completes the request; sampled at posedge.
- STALL  out  1  hold EX/MEM and earlier stages.
- RF_WE_MEMWB  out  1  write enable to the register file.
- WA_MEMWB  out  5  destination register.
- WD_MEMWB  out  32  write-back data.
- HALT_MEMWB  out  1  halt marker.
- MEM_ERR  out  1  sticky timeout error.

Behaviour:
- mem_op = D_MemRead | ~D_MEM_WEN.
- FSM states: IDLE, BUSY.
- IDLE, mem_op=0: at posedge, MEM/WB outputs load from EX/MEM. WD is ALU or PC+4 per RWSrc. Stays IDLE. STALL=0.
- IDLE, mem_op=1: at posedge, go to BUSY. Register MEM_REQ=1 and MEM_ADDR/WEN/BE/WDATA from EX/MEM. MEM/WB outputs load a bubble (RF_WE=0, HALT=0, WA=0, WD=0). STALL=1.
- BUSY: request fields held constant.
  - ACK=0: STALL=1; MEM/WB outputs load a bubble each cycle.
  - ACK=1 at posedge: MEM/WB outputs load the instruction. WD = aligned load data if RWSrc=1, else per RWSrc. MEM_REQ→0, state→IDLE.
- STALL = mem_op & ~(BUSY & MEM_ACK). STALL is combinational and deasserts in the ACK cycle, so upstream advances at the same edge.
- Minimum latency: a load with same-cycle ACK stalls exactly 1 cycle.
- A back-to-back memory op re-enters BUSY at the following edge. MEM_REQ is low for at least 1 cycle between requests.
- MEM_ACK is ignored in IDLE.
- Load alignment, byte offset o = ALUOUT[1:0]:
  - LB/LBU: byte o, sign- or zero-extended to 32 bits.
  - LH/LHU: halfword at o[1]; o[0] is ignored.
  - LW: full word.
  - Undefined LD_TYPE: full word.
- Store: MEM_WDATA = ST_DATA << (8*o). BE is passed through unchanged.
- RWSrc=3: WD=0.
- Reset (RSTn=0 at posedge), including mid-transaction:
  - state→IDLE; MEM_REQ=0, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0.
  - RF_WE_MEMWB=0, WA=0, WD=0, HALT=0, MEM_ERR=0.
  - Any late MEM_ACK after reset is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With it defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ACK.
  - When it reaches TIMEOUT_CYC, at that edge: abort, MEM_REQ→0, state→IDLE. MEM/WB outputs load RF_WE=0 and HALT_MEMWB=1. MEM_ERR sets and stays set until reset.
  - STALL deasserts in the abort cycle.
- Without it: BUSY waits indefinitely. No counter is present and MEM_ERR is tied 0.

Test Plan:
- ALU instruction: RWSrc=0, ALUOUT=0x1234, WA=5, RF_WE=1, no mem op → next edge WD_MEMWB=0x1234, WA=5, RF_WE=1, STALL never 1.
- LB: ALUOUT=0x103, RDATA=0x80FF_0000, ACK in first BUSY cycle → STALL high 1 cycle; WD=0xFFFF_FF80. Same case with LBU → WD=0x0000_0080.
- SW then SB: SB with ALUOUT=0x202, ST_DATA=0xAB, BE=0100, ACK after 3 cycles → MEM_ADDR=0x200, MEM_WDATA=0x00AB_0000, MEM_WEN=0; STALL for 4 cycles; RF_WE_MEMWB=0.
- Reset mid-BUSY: LW outstanding, RSTn=0 for 1 edge, then ACK=1 → MEM_REQ=0, state IDLE, no register write from the stale ACK.
- JAL-type instruction: RWSrc=2, ADD_PC=0x44 → WD=0x44. Back-to-back LW, LW → MEM_REQ shows a 1-cycle gap between requests.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, ACK never arrives → abort after 4 BUSY cycles; HALT_MEMWB=1, MEM_ERR=1 and stays 1.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage controller between the EX/MEM register and the
// register-file write-back. Runs a request/acknowledge transaction to a
// variable-latency data memory for loads and stores, stalls upstream while
// the transaction is in flight, aligns and extends load data, and registers
// the MEM/WB outputs.
// Optional build macro MEM_TIMEOUT_EN: aborts a request that stays in BUSY
// for TIMEOUT_CYC cycles without MEM_ACK, writes a halt bubble and sets the
// sticky MEM_ERR flag. Without it BUSY waits forever and MEM_ERR is 0.
module mem_access_stage #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        D_MemRead,
    input  logic        D_MEM_WEN,
    input  logic [3:0]  D_MEM_BE,
    input  logic [2:0]  LD_TYPE,
    input  logic [31:0] ALUOUT_EXMEM,
    input  logic [31:0] ST_DATA_EXMEM,
    input  logic [31:0] ADD_PC_EXMEM,
    input  logic [1:0]  RWSrc_EXMEM,
    input  logic        RF_WE_EXMEM,
    input  logic [4:0]  WA_EXMEM,
    input  logic        HALT_EXMEM,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_WEN,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        STALL,
    output logic        RF_WE_MEMWB,
    output logic [4:0]  WA_MEMWB,
    output logic [31:0] WD_MEMWB,
    output logic        HALT_MEMWB,
    output logic        MEM_ERR
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        mem_op;
    logic        start;        // IDLE -> BUSY, capture request fields
    logic        ack_done;     // BUSY completes on MEM_ACK
    logic        abort;        // BUSY gives up on timeout
    logic        timeout_hit;
    logic [1:0]  ofs;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wb_data;

    // The timeout counter has to be able to reach TIMEOUT_CYC.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << CNT_W)) begin : g_param_check
        $error("mem_access_stage: TIMEOUT_CYC does not fit in CNT_W bits");
    end

    assign mem_op = D_MemRead | ~D_MEM_WEN;
    assign ofs    = ALUOUT_EXMEM[1:0];

    // Load alignment: EX/MEM is held by STALL, so the live address selects the lane
    always_comb begin
        ld_byte = MEM_RDATA[7:0];
        case (ofs)
            2'd1:    ld_byte = MEM_RDATA[15:8];
            2'd2:    ld_byte = MEM_RDATA[23:16];
            2'd3:    ld_byte = MEM_RDATA[31:24];
            default: ld_byte = MEM_RDATA[7:0];
        endcase
        ld_half = ofs[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        ld_data = MEM_RDATA;
        case (LD_TYPE)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = MEM_RDATA;
        endcase
    end

    // Write-back source select
    always_comb begin
        wb_data = 32'b0;
        case (RWSrc_EXMEM)
            2'd0:    wb_data = ALUOUT_EXMEM;
            2'd1:    wb_data = ld_data;
            2'd2:    wb_data = ADD_PC_EXMEM;
            default: wb_data = 32'b0;
        endcase
    end

    // Next-state logic for the request FSM
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ack_done  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // MEM_ACK is deliberately not looked at here
                if (mem_op) begin
                    state_nxt = BUSY;
                    start     = 1'b1;
                end
            end
            BUSY: begin
                if (MEM_ACK) begin
                    state_nxt = IDLE;
                    ack_done  = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Release upstream in the same cycle the transaction ends
    assign STALL = mem_op & ~ack_done & ~abort;

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Request register: captured on entry to BUSY, held until completion
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            MEM_REQ   <= 1'b0;
            MEM_ADDR  <= 32'b0;
            MEM_WEN   <= 1'b1;
            MEM_BE    <= 4'b0;
            MEM_WDATA <= 32'b0;
        end else if (start) begin
            MEM_REQ   <= 1'b1;
            MEM_ADDR  <= {ALUOUT_EXMEM[31:2], 2'b00};
            MEM_WEN   <= D_MEM_WEN;
            MEM_BE    <= D_MEM_BE;
            MEM_WDATA <= ST_DATA_EXMEM << {ofs, 3'b000};
        end else if (ack_done || abort) begin
            MEM_REQ   <= 1'b0;
        end
    end

    // MEM/WB register: instruction when it retires, bubble otherwise
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            RF_WE_MEMWB <= 1'b0;
            WA_MEMWB    <= 5'b0;
            WD_MEMWB    <= 32'b0;
            HALT_MEMWB  <= 1'b0;
        end else if ((state == IDLE && !mem_op) || ack_done) begin
            RF_WE_MEMWB <= RF_WE_EXMEM;
            WA_MEMWB    <= WA_EXMEM;
            WD_MEMWB    <= wb_data;
            HALT_MEMWB  <= HALT_EXMEM;
        end else begin
            RF_WE_MEMWB <= 1'b0;
            WA_MEMWB    <= 5'b0;
            WD_MEMWB    <= 32'b0;
            HALT_MEMWB  <= abort;   // an aborted access halts the core
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    // Abort on the edge where the count of ACK-less BUSY cycles reaches TIMEOUT_CYC
    assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign MEM_ERR     = err_q;

    // Count BUSY cycles without ACK; cleared on every new request
    always_ff @(posedge CLK) begin
        if (!RSTn)                         to_cnt <= '0;
        else if (start)                    to_cnt <= '0;
        else if (state == BUSY && !MEM_ACK) to_cnt <= to_cnt + 1'b1;
    end

    // Sticky error, cleared only by reset
    always_ff @(posedge CLK) begin
        if (!RSTn)      err_q <= 1'b0;
        else if (abort) err_q <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign MEM_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written reset and
// timeout sequences, and randomized instructions checked against a
// byte-level reference model. The bench acts as the data memory.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        D_MemRead = 1'b0, D_MEM_WEN = 1'b1;
    logic [3:0]  D_MEM_BE = '0;
    logic [2:0]  LD_TYPE = '0;
    logic [31:0] ALUOUT_EXMEM = '0, ST_DATA_EXMEM = '0, ADD_PC_EXMEM = '0;
    logic [1:0]  RWSrc_EXMEM = '0;
    logic        RF_WE_EXMEM = 1'b0;
    logic [4:0]  WA_EXMEM = '0;
    logic        HALT_EXMEM = 1'b0;
    logic        MEM_REQ, MEM_WEN, STALL, RF_WE_MEMWB, HALT_MEMWB, MEM_ERR;
    logic [31:0] MEM_ADDR, MEM_WDATA, WD_MEMWB;
    logic [3:0]  MEM_BE;
    logic [4:0]  WA_MEMWB;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_ACK = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .D_MemRead(D_MemRead), .D_MEM_WEN(D_MEM_WEN), .D_MEM_BE(D_MEM_BE),
        .LD_TYPE(LD_TYPE), .ALUOUT_EXMEM(ALUOUT_EXMEM),
        .ST_DATA_EXMEM(ST_DATA_EXMEM), .ADD_PC_EXMEM(ADD_PC_EXMEM),
        .RWSrc_EXMEM(RWSrc_EXMEM), .RF_WE_EXMEM(RF_WE_EXMEM),
        .WA_EXMEM(WA_EXMEM), .HALT_EXMEM(HALT_EXMEM),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_WEN(MEM_WEN),
        .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .MEM_ACK(MEM_ACK), .STALL(STALL),
        .RF_WE_MEMWB(RF_WE_MEMWB), .WA_MEMWB(WA_MEMWB), .WD_MEMWB(WD_MEMWB),
        .HALT_MEMWB(HALT_MEMWB), .MEM_ERR(MEM_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wen;
        logic [3:0]  be;
        logic [2:0]  ldt;
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rws;
        logic        rfwe;
        logic [4:0]  wa;
        logic        halt;
        int          dly;        // BUSY cycles without ACK before the ACK cycle
        logic [31:0] exp_wd;
        logic [31:0] exp_wdata;
        int          exp_stall;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wen, input logic [3:0] be,
                                input logic [2:0] ldt, input logic [31:0] alu,
                                input logic [31:0] st, input logic [31:0] pc,
                                input logic [31:0] rdata, input logic [1:0] rws,
                                input logic rfwe, input logic [4:0] wa, input logic halt,
                                input int dly, input logic [31:0] exp_wd,
                                input logic [31:0] exp_wdata, input int exp_stall);
        vec_t v;
        v.rd = rd; v.wen = wen; v.be = be; v.ldt = ldt; v.alu = alu; v.st = st;
        v.pc = pc; v.rdata = rdata; v.rws = rws; v.rfwe = rfwe; v.wa = wa;
        v.halt = halt; v.dly = dly; v.exp_wd = exp_wd; v.exp_wdata = exp_wdata;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    // Reference: pick bytes out of the word arithmetically, extend by value range
    function automatic logic [31:0] ref_load(input logic [2:0] ldt, input logic [31:0] addr,
                                             input logic [31:0] word);
        longint w = longint'(word);
        int o = int'(addr % 4);
        int b[4];
        int h;
        for (int i = 0; i < 4; i++) b[i] = int'((w >> (8 * i)) % 256);
        h = b[(o / 2) * 2] + 256 * b[(o / 2) * 2 + 1];
        case (ldt)
            3'b000:  return 32'(b[o] >= 128 ? b[o] - 256 : b[o]);
            3'b100:  return 32'(b[o]);
            3'b001:  return 32'(h >= 32768 ? h - 65536 : h);
            3'b101:  return 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input vec_t v);
        case (v.rws)
            2'd0:    return v.alu;
            2'd1:    return ref_load(v.ldt, v.alu, v.rdata);
            2'd2:    return v.pc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input vec_t v);
        longint unsigned p = longint'(v.st) * (longint'(1) << (8 * (v.alu % 4)));
        return 32'(p % 64'h1_0000_0000);
    endfunction

    task automatic drive(input vec_t v);
        D_MemRead = v.rd; D_MEM_WEN = v.wen; D_MEM_BE = v.be; LD_TYPE = v.ldt;
        ALUOUT_EXMEM = v.alu; ST_DATA_EXMEM = v.st; ADD_PC_EXMEM = v.pc;
        RWSrc_EXMEM = v.rws; RF_WE_EXMEM = v.rfwe; WA_EXMEM = v.wa; HALT_EXMEM = v.halt;
    endtask

    // Called #1 after a posedge; returns #1 after the posedge where the instruction retires
    task automatic run_instr(input vec_t v, input string tag);
        int stalls = 0;
        drive(v);
        MEM_ACK = 1'b0;
        MEM_RDATA = $urandom;
        if (v.rd || !v.wen) begin
            @(negedge CLK);
            check({tag, "/req_idle"}, MEM_REQ, 0);
            if (STALL) stalls++;
            @(posedge CLK); #1;
            check({tag, "/req"}, MEM_REQ, 1);
            check({tag, "/addr"}, MEM_ADDR, v.alu & 32'hFFFF_FFFC);
            check({tag, "/wen"}, MEM_WEN, v.wen);
            check({tag, "/be"}, MEM_BE, v.be);
            if (!v.wen) check({tag, "/wdata"}, MEM_WDATA, v.exp_wdata);
            for (int k = 0; k <= v.dly; k++) begin
                MEM_ACK = (k == v.dly);
                MEM_RDATA = MEM_ACK ? v.rdata : $urandom;
                @(negedge CLK);
                if (STALL) stalls++;
                check({tag, "/bubble_we"}, RF_WE_MEMWB, 0);
                check({tag, "/req_held"}, MEM_REQ, 1);
                @(posedge CLK); #1;
            end
            MEM_ACK = 1'b0;
        end else begin
            @(negedge CLK);
            if (STALL) stalls++;
            check({tag, "/req_alu"}, MEM_REQ, 0);
            @(posedge CLK); #1;
        end
        check({tag, "/stall_cyc"}, stalls, v.exp_stall);
        check({tag, "/we"}, RF_WE_MEMWB, v.rfwe);
        check({tag, "/wa"}, WA_MEMWB, v.wa);
        check({tag, "/wd"}, WD_MEMWB, v.exp_wd);
        check({tag, "/halt"}, HALT_MEMWB, v.halt);
        check({tag, "/req_done"}, MEM_REQ, 0);
        check({tag, "/err"}, MEM_ERR, 0);
    endtask

    initial begin
        vec_t nop, v;
        nop = mk(0, 1, 4'h0, 3'b010, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        drive(nop);
        repeat (2) @(posedge CLK);
        #1;
        check("rst/req", MEM_REQ, 0);
        check("rst/wen", MEM_WEN, 1);
        check("rst/be", MEM_BE, 0);
        check("rst/addr", MEM_ADDR, 0);
        check("rst/wdata", MEM_WDATA, 0);
        check("rst/we", RF_WE_MEMWB, 0);
        check("rst/wd", WD_MEMWB, 0);
        check("rst/err", MEM_ERR, 0);
        RSTn = 1'b1;

        // Directed vectors: rd wen be ldt alu st pc rdata rws rfwe wa halt dly | wd wdata stall
        tbl.push_back(mk(0, 1, 4'h0, 3'b010, 32'h1234, 0, 0, 0, 2'd0, 1, 5, 0, 0, 32'h1234, 0, 0));
        tbl.push_back(mk(1, 1, 4'h0, 3'b000, 32'h103, 0, 0, 32'h80FF_0000, 2'd1, 1, 7, 0, 0, 32'hFFFF_FF80, 0, 1));
        tbl.push_back(mk(1, 1, 4'h0, 3'b100, 32'h103, 0, 0, 32'h80FF_0000, 2'd1, 1, 7, 0, 0, 32'h0000_0080, 0, 1));
        tbl.push_back(mk(0, 0, 4'hF, 3'b010, 32'h300, 32'hDEAD_BEEF, 0, 0, 2'd0, 0, 0, 0, 1, 32'h300, 32'hDEAD_BEEF, 2));
        tbl.push_back(mk(0, 0, 4'h4, 3'b010, 32'h202, 32'hAB, 0, 0, 2'd0, 0, 0, 0, 3, 32'h202, 32'h00AB_0000, 4));
        tbl.push_back(mk(0, 1, 4'h0, 3'b010, 32'h8, 0, 32'h44, 0, 2'd2, 1, 1, 0, 0, 32'h44, 0, 0));
        tbl.push_back(mk(1, 1, 4'h0, 3'b010, 32'h400, 0, 0, 32'h1234_5678, 2'd1, 1, 3, 0, 0, 32'h1234_5678, 0, 1));
        tbl.push_back(mk(1, 1, 4'h0, 3'b010, 32'h404, 0, 0, 32'hCAFE_F00D, 2'd1, 1, 4, 0, 1, 32'hCAFE_F00D, 0, 2));
        tbl.push_back(mk(1, 1, 4'h0, 3'b001, 32'h102, 0, 0, 32'h8001_7FFF, 2'd1, 1, 8, 0, 0, 32'hFFFF_8001, 0, 1));
        tbl.push_back(mk(1, 1, 4'h0, 3'b101, 32'h103, 0, 0, 32'h8001_7FFF, 2'd1, 1, 8, 0, 2, 32'h0000_8001, 0, 3));
        tbl.push_back(mk(1, 1, 4'h0, 3'b001, 32'h100, 0, 0, 32'h0000_F00F, 2'd1, 1, 9, 0, 0, 32'hFFFF_F00F, 0, 1));
        tbl.push_back(mk(1, 1, 4'h0, 3'b000, 32'h9, 0, 0, 32'h0000_7F00, 2'd1, 1, 10, 0, 0, 32'h0000_007F, 0, 1));
        tbl.push_back(mk(1, 1, 4'h0, 3'b111, 32'h101, 0, 0, 32'hA5A5_1234, 2'd1, 1, 11, 0, 0, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(0, 1, 4'h0, 3'b010, 32'h77, 0, 32'h88, 0, 2'd3, 1, 12, 0, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 3'b010, 32'h5, 0, 0, 0, 2'd0, 0, 0, 1, 0, 32'h5, 0, 0));
        for (int i = 0; i < tbl.size(); i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        // Reset clears a populated MEM/WB register
        v = mk(0, 1, 4'h0, 3'b010, 32'h55, 0, 0, 0, 2'd0, 1, 9, 1, 0, 32'h55, 0, 0);
        run_instr(v, "pre_rst");
        RSTn = 1'b0;
        @(posedge CLK); #1;
        check("rst_wb/we", RF_WE_MEMWB, 0);
        check("rst_wb/wa", WA_MEMWB, 0);
        check("rst_wb/wd", WD_MEMWB, 0);
        check("rst_wb/halt", HALT_MEMWB, 0);
        RSTn = 1'b1;

        // Reset while a load is outstanding, then a stale ACK
        v = mk(1, 1, 4'h0, 3'b010, 32'h500, 0, 0, 0, 2'd1, 1, 6, 0, 0, 0, 0, 0);
        drive(v);
        @(posedge CLK); #1;
        check("rst_busy/req", MEM_REQ, 1);
        @(posedge CLK); #1;
        RSTn = 1'b0;
        @(posedge CLK); #1;
        check("rst_busy/req0", MEM_REQ, 0);
        check("rst_busy/addr0", MEM_ADDR, 0);
        check("rst_busy/wen1", MEM_WEN, 1);
        RSTn = 1'b1;
        drive(nop);
        MEM_ACK = 1'b1;
        MEM_RDATA = 32'hBAD0_BAD0;
        @(negedge CLK);
        check("stale_ack/stall", STALL, 0);
        @(posedge CLK); #1;
        check("stale_ack/req", MEM_REQ, 0);
        check("stale_ack/we", RF_WE_MEMWB, 0);
        check("stale_ack/wd", WD_MEMWB, 0);
        // ACK present while IDLE with a load waiting must not complete it
        drive(v);
        @(negedge CLK);
        check("idle_ack/stall", STALL, 1);
        @(posedge CLK); #1;
        check("idle_ack/req", MEM_REQ, 1);
        MEM_RDATA = 32'h1122_3344;
        @(negedge CLK);
        check("idle_ack/stall_busy", STALL, 0);
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        check("idle_ack/wd", WD_MEMWB, 32'h1122_3344);
        check("idle_ack/we", RF_WE_MEMWB, 1);

        // Randomized instructions against the reference model
        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 4));
            logic [2:0] lt[7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
            v = mk(0, 1, 4'($urandom), lt[$urandom_range(0, 6)], $urandom, $urandom, $urandom,
                   $urandom, 2'd0, 1'($urandom), 5'($urandom), 0, int'($urandom_range(0, 2)), 0, 0, 0);
            case (kind)
                1: begin v.rd = 1; v.rws = 2'd1; end
                2: begin v.wen = 0; v.rfwe = 0; end
                3: v.rws = 2'd2;
                4: v.rws = 2'd3;
                default: ;
            endcase
            v.exp_wd = ref_wd(v);
            v.exp_wdata = ref_wdata(v);
            v.exp_stall = (v.rd || !v.wen) ? v.dly + 1 : 0;
            run_instr(v, $sformatf("rnd%0d", i));
        end

`ifdef MEM_TIMEOUT_EN
        // No ACK ever: abort on the 4th BUSY cycle, halt bubble, sticky error
        v = mk(1, 1, 4'h0, 3'b010, 32'h600, 0, 0, 0, 2'd1, 1, 2, 0, 0, 0, 0, 0);
        drive(v);
        MEM_ACK = 1'b0;
        @(posedge CLK); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check($sformatf("timeout/stall%0d", k), STALL, (k < 3) ? 1 : 0);
            @(posedge CLK); #1;
        end
        check("timeout/req", MEM_REQ, 0);
        check("timeout/halt", HALT_MEMWB, 1);
        check("timeout/we", RF_WE_MEMWB, 0);
        check("timeout/err", MEM_ERR, 1);
        drive(nop);
        repeat (3) @(posedge CLK);
        #1;
        check("timeout/err_sticky", MEM_ERR, 1);
`else
        // Without the timeout a long wait just keeps stalling
        v = mk(1, 1, 4'h0, 3'b001, 32'h602, 0, 0, 32'h7FFF_0000, 2'd1, 1, 2, 0, 10, 32'h0000_7FFF, 0, 11);
        run_instr(v, "long_wait");
        check("long_wait/err", MEM_ERR, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
